// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcodes and arbiter FSM encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_CLT  = 4'd8;
    localparam logic [3:0] ALU_CLTU = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam logic [3:0] ALU_OP_LAST = 4'd10;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; the port that did not win last time wins a tie.
// Latency: grant is combinational from the valids; history updates on the accept edge.
// Backpressure: history only advances when the caller signals accept.
module rr_arbiter2 (
    input  logic Clock,
    input  logic Reset_n,
    input  logic vld0,
    input  logic vld1,
    input  logic accept,
    output logic gnt_vld,
    output logic gnt_port
);

    logic last_grant;

    always_comb begin
        gnt_vld  = vld0 | vld1;
        gnt_port = 1'b0;
        if (vld0 && vld1)
            gnt_port = ~last_grant;
        else if (vld1)
            gnt_port = 1'b1;
    end

    // Resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= gnt_port;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between the pipeline (port 0) and debug unit (port 1).
// Latency: legal op responds 3 cycles after the accept cycle, illegal op 1 cycle after.
// Backpressure: one op in flight; new requests wait in IDLE until the response is taken.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Req0Valid,
    output logic                  Req0Ready,
    input  logic [OP_WIDTH-1:0]   Req0OpCode,
    input  logic [DATA_WIDTH-1:0] Req0X,
    input  logic [DATA_WIDTH-1:0] Req0Y,
    output logic                  Rsp0Valid,
    input  logic                  Rsp0Ready,
    output logic [DATA_WIDTH-1:0] Rsp0Z,
    output logic                  Rsp0Err,
    input  logic                  Req1Valid,
    output logic                  Req1Ready,
    input  logic [OP_WIDTH-1:0]   Req1OpCode,
    input  logic [DATA_WIDTH-1:0] Req1X,
    input  logic [DATA_WIDTH-1:0] Req1Y,
    output logic                  Rsp1Valid,
    input  logic                  Rsp1Ready,
    output logic [DATA_WIDTH-1:0] Rsp1Z,
    output logic                  Rsp1Err,
    output logic                  AluEnable,
    output logic [OP_WIDTH-1:0]   AluOpCode,
    output logic [DATA_WIDTH-1:0] AluX,
    output logic [DATA_WIDTH-1:0] AluY,
    input  logic [DATA_WIDTH-1:0] AluZ,
    output logic                  Busy
);

    arb_state_t            state, state_nxt;
    logic                  gnt_vld, gnt_port, accept, op_legal, rsp_rdy;
    logic [OP_WIDTH-1:0]   gnt_op, op_q;
    logic [DATA_WIDTH-1:0] gnt_x, gnt_y, x_q, y_q, z_q;
    logic                  port_q, err_q;

    rr_arbiter2 u_rr (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .vld0     (Req0Valid),
        .vld1     (Req1Valid),
        .accept   (accept),
        .gnt_vld  (gnt_vld),
        .gnt_port (gnt_port)
    );

    assign accept    = (state == ARB_IDLE) && gnt_vld;
    assign Req0Ready = accept && !gnt_port;
    assign Req1Ready = accept && gnt_port;

    assign gnt_op   = gnt_port ? Req1OpCode : Req0OpCode;
    assign gnt_x    = gnt_port ? Req1X : Req0X;
    assign gnt_y    = gnt_port ? Req1Y : Req0Y;
    assign op_legal = (32'(gnt_op) <= 32'(ALU_OP_LAST));
    assign rsp_rdy  = port_q ? Rsp1Ready : Rsp0Ready;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (accept) state_nxt = op_legal ? ARB_ISSUE : ARB_RESP;
            ARB_ISSUE: state_nxt = ARB_WAIT;
            ARB_WAIT:  state_nxt = ARB_RESP;
            ARB_RESP:  if (rsp_rdy) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        AluEnable = (state == ARB_ISSUE);
        Rsp0Valid = (state == ARB_RESP) && !port_q;
        Rsp1Valid = (state == ARB_RESP) && port_q;
        Busy      = (state != ARB_IDLE);
    end

    // Illegal ops preload the error response here and skip the ALU entirely.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            op_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            err_q  <= 1'b0;
            port_q <= 1'b0;
        end else if (accept) begin
            op_q   <= gnt_op;
            x_q    <= gnt_x;
            y_q    <= gnt_y;
            port_q <= gnt_port;
            if (!op_legal) begin
                z_q   <= '0;
                err_q <= 1'b1;
            end
        end else if (state == ARB_WAIT) begin
            z_q   <= AluZ;
            err_q <= 1'b0;
        end
    end

    assign AluOpCode = op_q;
    assign AluX      = x_q;
    assign AluY      = y_q;

    assign Rsp0Z   = port_q ? '0 : z_q;
    assign Rsp1Z   = port_q ? z_q : '0;
    assign Rsp0Err = !port_q && err_q;
    assign Rsp1Err = port_q && err_q;

endmodule
